// File: rtl/dispatch_pkg.sv
// Shared types and constants for the instruction dispatcher: FSM states,
// the default type-field width and the engine channel indices.
package dispatch_pkg;

  localparam int DISPATCH_TYPE_W = 4;

  localparam int CH_COMPUTE = 0;
  localparam int CH_WEIGHT  = 1;
  localparam int CH_BIAS    = 2;
  localparam int CH_DATA    = 3;
  localparam int CH_WBACK   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_POP   = 2'd2
  } state_t;

endpackage

// File: rtl/inst_dispatch_if.sv
// Dispatcher bus: instruction FIFO head/pop, pause control and the engine
// channel idle/configure signals.
interface inst_dispatch_if
  import dispatch_pkg::*;
#(
  parameter int N_CH      = 5,
  parameter int TYPE_W    = DISPATCH_TYPE_W,
  parameter int PAYLOAD_W = 208
);
  localparam int INST_LEN = TYPE_W + PAYLOAD_W + N_CH;

  logic [INST_LEN-1:0]  inst;
  logic                 inst_empty;
  logic                 inst_req;
  logic                 dispatch_en;
  logic [N_CH-1:0]      ch_idle;
  logic [N_CH-1:0]      ch_conf;
  logic [PAYLOAD_W-1:0] ch_payload;
  logic [TYPE_W-1:0]    ch_sel;
  logic                 err_illegal;
  logic                 busy;

  modport master (
    input  inst, inst_empty, dispatch_en, ch_idle,
    output inst_req, ch_conf, ch_payload, ch_sel, err_illegal, busy
  );

  modport slave (
    output inst, inst_empty, dispatch_en, ch_idle,
    input  inst_req, ch_conf, ch_payload, ch_sel, err_illegal, busy
  );

endinterface

// File: rtl/dispatch_hold_cnt.sv
// Per-channel post-configure hold-off: reports busy for IDLE_LAT cycles after
// a configure strobe, covering the engine's lag in dropping its idle flag.
module dispatch_hold_cnt #(
  parameter int IDLE_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  logic [2:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= 3'(IDLE_LAT);
    end else if (cnt_reg != 3'd0) begin
      cnt_reg <= cnt_reg - 3'd1;
    end
  end

  assign busy = (cnt_reg != 3'd0);

endmodule

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: pops FIFO words, checks dependency/exclusivity
// scoreboard and issues to one of N_CH channels. DISPATCH_PERF_CNT_EN adds counters.
module inst_dispatch
  import dispatch_pkg::*;
#(
  parameter int              N_CH      = 5,
  parameter int              TYPE_W    = DISPATCH_TYPE_W,
  parameter int              PAYLOAD_W = 208,
  parameter logic [N_CH-1:0] EXCL_MASK = 5'b11110,
  parameter int              IDLE_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_dispatch_if.master     bus
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         issue_count
`endif
);

  localparam int INST_LEN = TYPE_W + PAYLOAD_W + N_CH;
  localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

  state_t               state_reg, state_next;
  logic [INST_LEN-1:0]  inst_reg, inst_next;
  logic [N_CH-1:0]      conf_reg, conf_next;
  logic                 req_reg, req_next;
  logic [PAYLOAD_W-1:0] payload_reg, payload_next;
  logic [TYPE_W-1:0]    sel_reg, sel_next;
  logic                 err_reg, err_next;

  logic [TYPE_W-1:0]    typ;
  logic [N_CH-1:0]      dep;
  logic [N_CH-1:0]      tsel;
  logic [N_CH-1:0]      hold_busy;
  logic [N_CH-1:0]      eb;
  logic                 illegal;
  logic                 ready;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_hold
    dispatch_hold_cnt #(.IDLE_LAT(IDLE_LAT)) u_hold (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (conf_reg[gi]),
      .busy  (hold_busy[gi])
    );
  end

  assign typ     = inst_reg[TYPE_W-1:0];
  assign dep     = inst_reg[INST_LEN-1 -: N_CH];
  // One-hot of the target channel; shifts out to zero for an illegal type.
  assign tsel    = ONE << typ;
  assign illegal = (int'(typ) >= N_CH);
  assign eb      = ~bus.ch_idle | hold_busy;
  assign ready   = ~|(dep & eb)
                 & ~(|(EXCL_MASK & tsel) & |(EXCL_MASK & eb))
                 & ~|(eb & tsel);

  always_comb begin
    state_next   = state_reg;
    inst_next    = inst_reg;
    conf_next    = '0;
    req_next     = 1'b0;
    payload_next = payload_reg;
    sel_next     = sel_reg;
    err_next     = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (!bus.inst_empty && bus.dispatch_en) begin
          inst_next  = bus.inst;
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal) begin
          err_next   = 1'b1;
          req_next   = 1'b1;
          state_next = S_POP;
        end else if (ready) begin
          conf_next    = tsel;
          req_next     = 1'b1;
          payload_next = inst_reg[TYPE_W +: PAYLOAD_W];
          sel_next     = typ;
          state_next   = S_POP;
        end
      end
      S_POP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      inst_reg    <= '0;
      conf_reg    <= '0;
      req_reg     <= 1'b0;
      payload_reg <= '0;
      sel_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      inst_reg    <= inst_next;
      conf_reg    <= conf_next;
      req_reg     <= req_next;
      payload_reg <= payload_next;
      sel_reg     <= sel_next;
      err_reg     <= err_next;
    end
  end

  assign bus.inst_req    = req_reg;
  assign bus.ch_conf     = conf_reg;
  assign bus.ch_payload  = payload_reg;
  assign bus.ch_sel      = sel_reg;
  assign bus.err_illegal = err_reg;
  assign bus.busy        = (state_reg != S_IDLE);

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_reg, issue_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_reg <= '0;
      issue_reg <= '0;
    end else begin
      if (state_reg == S_CHECK && !illegal && !ready && stall_reg != '1)
        stall_reg <= stall_reg + 32'd1;
      if (|conf_reg && issue_reg != '1)
        issue_reg <= issue_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
  assign issue_count  = issue_reg;
`endif

endmodule

// File: tb/tb_inst_dispatch.sv
// Randomized bench for inst_dispatch: a queue-backed FIFO feeds the design and a
// timestamp-based scoreboard predicts every strobe and registered output.
module tb_inst_dispatch;
  import dispatch_pkg::*;

  localparam int N_CH      = 5;
  localparam int TYPE_W    = 4;
  localparam int PAYLOAD_W = 208;
  localparam int INST_LEN  = TYPE_W + PAYLOAD_W + N_CH;
  localparam int LAT       = 3;
  localparam logic [N_CH-1:0] EXCL = 5'b11110;
  localparam int N_CYC     = 4000;
  localparam int DRAIN_AT  = 3600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_dispatch_if #(.N_CH(N_CH), .TYPE_W(TYPE_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_cycles, issue_count;
`endif

  inst_dispatch #(
    .N_CH(N_CH), .TYPE_W(TYPE_W), .PAYLOAD_W(PAYLOAD_W),
    .EXCL_MASK(EXCL), .IDLE_LAT(LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .issue_count  (issue_count)
`endif
  );

  // Environment FIFO (head presented first-word-fall-through)
  logic [INST_LEN-1:0] fifo_q[$];

  // Scoreboard state: what the dispatcher holds and when each channel was configured
  bit                   m_have, m_strobe, m_err;
  int                   m_conf_ch;
  logic [INST_LEN-1:0]  m_inst;
  logic [PAYLOAD_W-1:0] m_payload;
  logic [TYPE_W-1:0]    m_sel;
  int                   last_conf[N_CH];
  int                   m_stall, m_issue;
  int                   edge_n;
  int                   n_checks, n_fail, n_conf_seen;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  // A channel is busy if it reports non-idle or was configured within the last LAT edges.
  function automatic bit ch_busy(int k);
    return !bus.ch_idle[k] || (edge_n > last_conf[k] && edge_n - last_conf[k] <= LAT);
  endfunction

  function automatic logic [INST_LEN-1:0] gen_inst();
    logic [PAYLOAD_W-1:0] p = '0;
    logic [N_CH-1:0] d;
    logic [TYPE_W-1:0] t;
    for (int w = 0; w < 7; w++) p = {p[PAYLOAD_W-33:0], 32'($urandom)};
    for (int k = 0; k < N_CH; k++) d[k] = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 11) == 0) t = TYPE_W'($urandom_range(N_CH, 15));
    else                            t = TYPE_W'($urandom_range(0, N_CH - 1));
    return {d, p, t};
  endfunction

  task automatic model_reset();
    m_have = 0; m_strobe = 0; m_err = 0; m_conf_ch = -1;
    m_payload = '0; m_sel = '0; m_stall = 0; m_issue = 0;
    for (int k = 0; k < N_CH; k++) last_conf[k] = -100;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] excl_v, dep;
    int t;
    bit ok;
    excl_v = EXCL;
    if (!rst_n) begin
      model_reset();
    end else if (m_strobe) begin
      if (m_conf_ch >= 0) begin
        last_conf[m_conf_ch] = edge_n;
        m_issue++;
      end
      m_strobe = 0;
      m_conf_ch = -1;
    end else if (m_have) begin
      t   = int'(m_inst[TYPE_W-1:0]);
      dep = m_inst[INST_LEN-1 -: N_CH];
      if (t >= N_CH) begin
        m_err = 1; m_strobe = 1; m_have = 0;
      end else begin
        ok = !ch_busy(t);
        for (int k = 0; k < N_CH; k++) begin
          if (dep[k] && ch_busy(k)) ok = 0;
          if (excl_v[t] && excl_v[k] && ch_busy(k)) ok = 0;
        end
        if (ok) begin
          m_strobe = 1; m_have = 0; m_conf_ch = t;
          m_payload = m_inst[TYPE_W +: PAYLOAD_W];
          m_sel = m_inst[TYPE_W-1:0];
        end else begin
          m_stall++;
        end
      end
    end else if (fifo_q.size() != 0 && bus.dispatch_en) begin
      m_have = 1;
      m_inst = fifo_q[0];
    end
  endtask

  task automatic compare_outputs();
    logic [N_CH-1:0] exp_conf;
    exp_conf = '0;
    if (m_strobe && m_conf_ch >= 0) exp_conf[m_conf_ch] = 1'b1;
    check_val("inst_req",    256'(bus.inst_req),    256'(m_strobe));
    check_val("ch_conf",     256'(bus.ch_conf),     256'(exp_conf));
    check_val("ch_payload",  256'(bus.ch_payload),  256'(m_payload));
    check_val("ch_sel",      256'(bus.ch_sel),      256'(m_sel));
    check_val("err_illegal", 256'(bus.err_illegal), 256'(m_err));
    check_val("busy",        256'(bus.busy),        256'(m_have || m_strobe));
`ifdef DISPATCH_PERF_CNT_EN
    check_val("stall_cycles", 256'(stall_cycles), 256'(m_stall));
    check_val("issue_count",  256'(issue_count),  256'(m_issue));
`endif
  endtask

  task automatic drive_inputs(input int cyc);
    bit draining;
    draining = (cyc >= DRAIN_AT);
    if (bus.inst_req && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (!draining && fifo_q.size() < 4 && $urandom_range(0, 2) == 0) fifo_q.push_back(gen_inst());
    for (int k = 0; k < N_CH; k++) begin
      if (draining)                                    bus.ch_idle[k] = 1'b1;
      else if (bus.ch_idle[k] && $urandom_range(0, 7) == 0)  bus.ch_idle[k] = 1'b0;
      else if (!bus.ch_idle[k] && $urandom_range(0, 3) == 0) bus.ch_idle[k] = 1'b1;
    end
    if (draining)                                         bus.dispatch_en = 1'b1;
    else if (bus.dispatch_en && $urandom_range(0, 15) == 0) bus.dispatch_en = 1'b0;
    else if (!bus.dispatch_en && $urandom_range(0, 3) == 0) bus.dispatch_en = 1'b1;
    rst_n = !(cyc < 2 || cyc == 1800 || cyc == 1801);
    bus.inst_empty = (fifo_q.size() == 0);
    bus.inst       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_conf_seen = 0; edge_n = 0;
    model_reset();
    bus.inst = '0;
    bus.inst_empty = 1'b1;
    bus.dispatch_en = 1'b1;
    bus.ch_idle = '1;
    rst_n = 1'b0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      edge_n++;
      model_step();
      @(negedge clk);
      compare_outputs();
      if (|bus.ch_conf) n_conf_seen++;
      drive_inputs(cyc);
    end
    check_val("drained", 256'(fifo_q.size() == 0 && !bus.busy), 256'(1));
    check_val("issue_activity", 256'(n_conf_seen > 150), 256'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_dispatch.md
# inst_dispatch

Parametrised instruction dispatcher for the accelerator. It pops packed instructions from the instruction FIFO and decodes the type and dependency fields. Each instruction is issued to one of N_CH engine channels (compute, weight/bias/data load, write-back, …) once its dependency and exclusivity conditions are met. It replaces the fixed four-loader controller with a channel-count-generic scoreboard, post-issue busy masking, illegal-type trapping and a pause control.

## Interface
- N_CH, 5: number of engine channels; instruction type t selects channel t.
- TYPE_W, 4: type field width, instruction bits [TYPE_W-1:0].
- PAYLOAD_W, 208: payload width, bits [TYPE_W+PAYLOAD_W-1:TYPE_W].
- INST_LEN, TYPE_W+PAYLOAD_W+N_CH: total width; dependency mask in the top N_CH bits.
- EXCL_MASK, 5'b11110: channels sharing the DDR port; issuing to one needs all masked channels idle.
- IDLE_LAT, 1: cycles after conf during which the target channel counts as busy regardless of ch_idle (1..7).
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- inst  in  INST_LEN  head of instruction FIFO (first-word-fall-through).
- inst_empty  in  1  FIFO empty.
- inst_req  out  1  one-cycle pop strobe.
- dispatch_en  in  1  low: finish the current instruction, start no new one.
- ch_idle  in  N_CH  per-channel idle.
- ch_conf  out  N_CH  one-hot, one-cycle configure strobe.
- ch_payload  out  PAYLOAD_W  payload of the last issued instruction; stable until the next issue.
- ch_sel  out  TYPE_W  type of the last issued instruction (drives the DDR mux select).
- err_illegal  out  1  sticky: an instruction with type ≥ N_CH was seen.
- busy  out  1  FSM not in S_IDLE.

## Operation
- Decode: type = inst[TYPE_W-1:0]; dep = inst[INST_LEN-1 -: N_CH]; payload between the two.
- Effective busy: eb[k] = ~ch_idle[k] | (hold_cnt[k] ≠ 0). hold_cnt[k] loads IDLE_LAT on ch_conf[k] and decrements to 0.
- ready = ~|(dep & eb) & ~(EXCL_MASK[type] & |(EXCL_MASK & eb)) & ~eb[type].
- FSM states:
  - S_IDLE: if ~inst_empty & dispatch_en, register inst and go to S_CHECK.
  - S_CHECK with type ≥ N_CH: set err_illegal, pulse inst_req (no conf), go to S_POP.
  - S_CHECK with ready: pulse ch_conf[type] and inst_req, update ch_payload/ch_sel, go to S_POP.
  - S_CHECK not ready: stay, re-evaluate every cycle.
  - S_POP: strobes low, go to S_IDLE (this cycle lets the FIFO present the next word).
- dispatch_en low in S_CHECK does not abort; the instruction issues when ready.
- A dep bit on the target's own channel is redundant with ~eb[type]; no error.
- err_illegal clears only on reset.

## Timing
- Reset values: inst_req 0, ch_conf 0, ch_payload 0, ch_sel 0, err_illegal 0, busy 0, all hold_cnt 0, state S_IDLE.
- Reset asserted mid-instruction: the instruction is not popped and no strobe fires; it is re-read after reset.
- Minimum latency: FIFO non-empty at edge T → registered at T+1 → ch_conf/inst_req high during T+1..T+2. Peak throughput is one instruction per 3 cycles.
- ch_conf and inst_req are always asserted in the same cycle, for exactly one cycle.
- Back-to-back instructions to the same channel: the second waits at least IDLE_LAT cycles after the first conf, then for ch_idle.
- ch_idle changing in the same cycle as the ready evaluation: the registered-input value of that cycle is used; no combinational path from ch_idle to ch_conf.

## Configuration
- DISPATCH_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and issue_count[31:0].
  - stall_cycles increments each cycle in S_CHECK with ready low.
  - issue_count increments on every ch_conf.
  - Both saturate at all-ones and reset to 0.
- DISPATCH_PERF_CNT_EN undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package dispatch_pkg: state enum (S_IDLE, S_CHECK, S_POP), type field width, channel index constants (CH_COMPUTE=0, CH_WEIGHT=1, CH_BIAS=2, CH_DATA=3, CH_WBACK=4).
- One sub-module, dispatch_hold_cnt: per-channel IDLE_LAT down-counter, instantiated N_CH times in a generate loop.

## Test plan
- Single load: type 1, dep 0, all idle → ch_conf=5'b00010 and inst_req together, 2 cycles after inst_empty falls; ch_payload equals inst payload.
- Dependency stall: type 0, dep=5'b00010, ch_idle[1]=0 for 10 cycles → no conf for 10 cycles (stall_cycles=10 with macro); conf on the cycle after ch_idle[1] rises.
- Exclusivity: ch_idle[3]=0, issue type 2 → held until ch 3 idle. Issue type 0 with ch 3 busy → issues immediately.
- Hold-off: two type-1 instructions back-to-back, IDLE_LAT=3, ch_idle tied 1 → confs ≥4 cycles apart.
- Illegal type 7 → err_illegal=1, inst_req pulses, ch_conf stays 0; a following type-0 instruction issues normally.
- dispatch_en dropped while in S_CHECK → pending instruction still issues; the next FIFO word is not registered until dispatch_en returns.
